// File: rtl/alu.sv
// alu: purely combinational integer ALU.
// Ports:
//   i_op1, i_op2  operands (XLEN)
//   i_alu_ctrl    opcode, see parameters.vh
//   o_result      result; compare opcodes return 0/1 in bit 0
`include "parameters.vh"

module alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [3:0]      i_alu_ctrl,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;

    assign shamt = i_op2[SH_W-1:0];

    always_comb begin
        o_result = '0;
        case (i_alu_ctrl)
            `ADD:    o_result = i_op1 + i_op2;
            `SUB:    o_result = i_op1 - i_op2;
            `AND:    o_result = i_op1 & i_op2;
            `OR:     o_result = i_op1 | i_op2;
            `XOR:    o_result = i_op1 ^ i_op2;
            `SLL:    o_result = i_op1 << shamt;
            `SRL:    o_result = i_op1 >> shamt;
            `SRA:    o_result = $unsigned($signed(i_op1) >>> shamt);
            `SLT:    o_result[0] = ($signed(i_op1) < $signed(i_op2));
            `SLTU:   o_result[0] = (i_op1 < i_op2);
            `EQ:     o_result[0] = (i_op1 == i_op2);
            `NE:     o_result[0] = (i_op1 != i_op2);
            `LT:     o_result[0] = ($signed(i_op1) < $signed(i_op2));
            `GE:     o_result[0] = ($signed(i_op1) >= $signed(i_op2));
            `LTU:    o_result[0] = (i_op1 < i_op2);
            `GEU:    o_result[0] = (i_op1 >= i_op2);
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/parameters.vh
// Shared ALU opcode encodings and the round-robin pointer encoding used by
// alu_arbiter. Included by every RTL file that decodes or drives an opcode.
`ifndef PARAMETERS_VH
`define PARAMETERS_VH

`define ADD  4'd0
`define SUB  4'd1
`define AND  4'd2
`define OR   4'd3
`define XOR  4'd4
`define SLL  4'd5
`define SRL  4'd6
`define SRA  4'd7
`define SLT  4'd8
`define SLTU 4'd9
`define EQ   4'd10
`define NE   4'd11
`define LT   4'd12
`define GE   4'd13
`define LTU  4'd14
`define GEU  4'd15

// Round-robin pointer: which port wins the next contended cycle.
`define ARB_P0 1'b0
`define ARB_P1 1'b1

`endif

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between the execute stage (port 0)
// and the branch/compare unit (port 1). Each port has a valid/ready request
// handshake and a one-entry registered response slot drained by its own
// valid/ready handshake. Contention is resolved round-robin (or port 0 fixed
// priority) and counted in a saturating counter.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_reqN_valid / o_reqN_ready       request handshake, N = 0,1
//   i_reqN_op1, i_reqN_op2            operands (XLEN)
//   i_reqN_alu_ctrl                   opcode (parameters.vh)
//   o_rspN_valid / i_rspN_ready       response slot handshake
//   o_rspN_result                     registered alu result for port N
//   o_conflict_cnt                    cycles with both requests valid (saturating)
`include "parameters.vh"

module alu_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [XLEN-1:0]  i_req0_op1,
    input  logic [XLEN-1:0]  i_req0_op2,
    input  logic [3:0]       i_req0_alu_ctrl,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [XLEN-1:0]  i_req1_op1,
    input  logic [XLEN-1:0]  i_req1_op2,
    input  logic [3:0]       i_req1_alu_ctrl,
    output logic             o_rsp0_valid,
    input  logic             i_rsp0_ready,
    output logic [XLEN-1:0]  o_rsp0_result,
    output logic             o_rsp1_valid,
    input  logic             i_rsp1_ready,
    output logic [XLEN-1:0]  o_rsp1_result,
    output logic [CNT_W-1:0] o_conflict_cnt
);

    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [XLEN-1:0]  rsp0_result_q, rsp0_result_d;
    logic [XLEN-1:0]  rsp1_result_q, rsp1_result_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             can0, can1;
    logic             want0, want1;
    logic             prefer1;
    logic             grant0, grant1;
    logic             contend;
    logic [XLEN-1:0]  alu_op1, alu_op2, alu_result;
    logic [3:0]       alu_ctrl;

    // A slot can take a new result when empty or when it is draining this cycle.
    always_comb begin
        can0    = !rsp0_valid_q || i_rsp0_ready;
        can1    = !rsp1_valid_q || i_rsp1_ready;
        want0   = i_req0_valid && can0;
        want1   = i_req1_valid && can1;
        prefer1 = (FIXED_PRIO == 0) && (rr_q == `ARB_P1);
        // Port 1 wins a two-way tie only when the pointer says so; a port whose
        // slot cannot accept never blocks the other one.
        grant0  = want0 && (!want1 || !prefer1);
        grant1  = want1 && !grant0;
        contend = i_req0_valid && i_req1_valid;
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    // Operand mux defaults to port 0 when nothing is granted.
    always_comb begin
        alu_op1  = grant1 ? i_req1_op1      : i_req0_op1;
        alu_op2  = grant1 ? i_req1_op2      : i_req0_op2;
        alu_ctrl = grant1 ? i_req1_alu_ctrl : i_req0_alu_ctrl;
    end

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .i_op1      (alu_op1),
        .i_op2      (alu_op2),
        .i_alu_ctrl (alu_ctrl),
        .o_result   (alu_result)
    );

    always_comb begin
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;

        if (grant0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_result;
        end else if (rsp0_valid_q && i_rsp0_ready) begin
            rsp0_valid_d  = 1'b0;
        end

        if (grant1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_result;
        end else if (rsp1_valid_q && i_rsp1_ready) begin
            rsp1_valid_d  = 1'b0;
        end

        if (contend) begin
            if (grant0 || grant1) begin
                rr_d = grant0 ? `ARB_P1 : `ARB_P0;
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rr_q          <= `ARB_P0;
            cnt_q         <= '0;
        end else begin
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign o_rsp0_valid   = rsp0_valid_q;
    assign o_rsp0_result  = rsp0_result_q;
    assign o_rsp1_valid   = rsp1_valid_q;
    assign o_rsp1_result  = rsp1_result_q;
    assign o_conflict_cnt = cnt_q;

endmodule
